// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller.
//   NUM_DIGITS_DEF : default number of multiplexed digits
//   scan_state_e   : controller state encoding (IDLE / SCAN)
package display_pkg;

  localparam int NUM_DIGITS_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Shadow-register load handshake between a data source and the scan controller.
//   load_req : source holds high until load_ack is seen
//   data     : packed nibbles, digit 0 in bits [3:0]
//   load_ack : one-cycle pulse, data has been captured into the shadow register
interface display_scan_ctrl_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) ();

  logic                    load_req;
  logic [4*NUM_DIGITS-1:0] data;
  logic                    load_ack;

  modport master (output load_req, output data, input load_ack);
  modport slave  (input load_req, input data, output load_ack);

endinterface

// File: rtl/display_scan_ctrl_tick.sv
// Refresh divider for the scan controller.
//   clk, reset : clock and synchronous active-high reset
//   run        : count while high, counter cleared to 0 while low
//   tick       : high while the counter sits at REFRESH_DIV-1 (last cycle of a slot)
module scan_tick_gen #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int             CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter only leaves 0 while scanning, so tick cannot fire in IDLE.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scan controller driving an external 4-to-7 decoder.
//   clk, reset  : clock and synchronous active-high reset
//   enable      : 1 = scan digits, 0 = blanked/idle
//   blank_mask  : bit i suppresses digit i anode (combinational)
//   ld          : shadow-register load handshake (slave side)
//   digit_code  : nibble of the active digit, registered
//   anode       : active-low digit enables, at most one low
//   frame_done  : one-cycle pulse after the last digit's slot ends
//
// state | meaning
// IDLE  | anodes off, counter/pointer held 0, loads accepted immediately
// SCAN  | digits driven in turn, loads accepted only at the frame boundary
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  display_scan_ctrl_if.slave    ld,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  frame_done
);

  localparam int            PW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [3:0]              code_q, code_d;
  logic                    ack_q, ack_d;
  logic                    fd_q, fd_d;
  logic                    done_q, done_d;
  logic                    tick;
  logic                    run;
  logic                    boundary;
  logic                    capture;

  // Counter runs only while staying in SCAN, so it is already 0 on the
  // first IDLE cycle and on the first cycle of a fresh scan.
  assign run = (state_q == ST_SCAN) && enable;

  scan_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = enable ? ST_SCAN : ST_IDLE;
  end

  always_comb begin
    anode = '1;
    if (state_q == ST_SCAN && !blank_mask[ptr_q]) begin
      anode[ptr_q] = 1'b0;
    end
  end

  always_comb begin
    boundary = (state_q == ST_SCAN) && tick && (ptr_q == PTR_LAST);
    // done_q blocks a second capture until load_req has been seen low.
    capture  = ld.load_req && !done_q && ((state_q == ST_IDLE) || boundary);

    done_d = done_q;
    if (capture) begin
      done_d = 1'b1;
    end else if (!ld.load_req) begin
      done_d = 1'b0;
    end

    ptr_d = ptr_q;
    if (state_d != ST_SCAN) begin
      ptr_d = '0;
    end else if (state_q == ST_SCAN && tick) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    end

    shadow_d = capture ? ld.data : shadow_q;
    // Looked up from next-cycle pointer and shadow so code and anode switch together.
    code_d   = shadow_d[{ptr_d, 2'b00} +: 4];
    ack_d    = capture;
    fd_d     = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      shadow_q <= '0;
      code_q   <= '0;
      ack_q    <= 1'b0;
      fd_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
      ack_q    <= ack_d;
      fd_q     <= fd_d;
      done_q   <= done_d;
    end
  end

  assign digit_code  = code_q;
  assign frame_done  = fd_q;
  assign ld.load_ack = ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] blank_mask;
  logic [3:0]   digit_code;
  logic [N-1:0] anode;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl_if #(.NUM_DIGITS(N)) ld ();

  display_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .blank_mask (blank_mask),
    .ld         (ld),
    .digit_code (digit_code),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       scan;
    int         ptr;
    logic       ack;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: time since scan start decides the digit; frame
  // boundary is the last cycle of each FRAME-cycle period.
  logic         m_scan = 1'b0;
  int           m_t = 0;
  logic [4*N-1:0] m_shadow = '0;
  logic         m_done = 1'b0;

  always @(posedge clk) begin : model
    exp_t e;
    logic boundary;
    logic capture;
    int   p;
    if (reset) begin
      m_scan = 1'b0; m_t = 0; m_shadow = '0; m_done = 1'b0;
      e.ack = 1'b0; e.fd = 1'b0;
    end else begin
      boundary = m_scan && ((m_t % FRAME) == FRAME - 1);
      capture  = ld.load_req && !m_done && (!m_scan || boundary);
      e.fd  = boundary;
      e.ack = capture;
      if (capture) begin
        m_shadow = ld.data;
        m_done   = 1'b1;
      end else if (!ld.load_req) begin
        m_done = 1'b0;
      end
      m_t    = (m_scan && enable) ? m_t + 1 : 0;
      m_scan = enable;
    end
    p = m_scan ? (m_t / DIV) % N : 0;
    e.scan = m_scan;
    e.ptr  = p;
    e.code = m_shadow[4*p +: 4];
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [N-1:0] an;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      an = '1;
      if (e.scan && !blank_mask[e.ptr]) an[e.ptr] = 1'b0;
      check("digit_code", 32'(digit_code), 32'(e.code));
      check("anode",      32'(anode),      32'(an));
      check("load_ack",   32'(ld.load_ack), 32'(e.ack));
      check("frame_done", 32'(frame_done), 32'(e.fd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc(1);
      got = ld.load_ack;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: load_ack got none within %0d cycles, required a pulse", tag, budget);
    end
    ld.load_req = 1'b0;
  endtask

  task automatic restart_scan();
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; blank_mask = '0;
    ld.load_req = 1'b0; ld.data = '0;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // IDLE load: ack exactly one edge later, then a full frame of 1,2,3,4
    ld.data = 16'h4321; ld.load_req = 1'b1;
    wait_ack(1, "idle_load");
    enable = 1'b1;
    cyc(FRAME + 2);

    // Load requested at pointer 1 waits for the frame boundary
    restart_scan();
    cyc(DIV);
    ld.data = 16'hABCD; ld.load_req = 1'b1;
    wait_ack(FRAME + 2, "boundary_load");
    cyc(FRAME);

    // Blanking digit 2
    blank_mask = 4'b0100;
    cyc(2 * FRAME);
    blank_mask = '0;

    // Enable dropped mid digit 2, then restart from digit 0
    restart_scan();
    cyc(2 * DIV + 1);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(FRAME + 1);

    // Enable fall coinciding with a frame-boundary load
    restart_scan();
    ld.data = 16'h9E5F; ld.load_req = 1'b1;
    cyc(FRAME - 1);
    enable = 1'b0;
    wait_ack(1, "fall_boundary_load");
    cyc(2);

    // Reset while a load waits for the boundary; reset overrides enable
    enable = 1'b1;
    cyc(1);
    ld.data = 16'h7A3C; ld.load_req = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    wait_ack(1, "post_reset_load");
    cyc(FRAME);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) blank_mask = N'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      if (!ld.load_req && $urandom_range(0, 24) == 0) begin
        ld.data     = (4*N)'($urandom);
        ld.load_req = 1'b1;
      end else if (ld.load_req && ld.load_ack) begin
        ld.load_req = 1'b0;
      end
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of time-multiplexed digits sharing one 4-to-7 segment decoder.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit is driven before advancing (minimum 2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enable  input  1  1 = scan digits, 0 = display blanked/idle.
REQ-007 load_req  input  1  request to transfer data into the display shadow register; held high until load_ack.
REQ-008 data  input  4*NUM_DIGITS  packed nibbles, digit 0 in bits [3:0].
REQ-009 blank_mask  input  NUM_DIGITS  bit i = 1 suppresses digit i anode.
REQ-010 digit_code  output  4  nibble for the active digit, wired to decoder inputs {a,b,c,d}.
REQ-011 anode  output  NUM_DIGITS  active-low digit enables, at most one low.
REQ-012 load_ack  output  1  one-cycle pulse: data captured this cycle.
REQ-013 frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Function
REQ-014 SHALL implement FSM states IDLE and SCAN.
REQ-015 IDLE: refresh counter and digit pointer held 0, anode all 1s, digit_code = shadow nibble 0.
REQ-016 IDLE -> SCAN on the cycle after enable sampled 1; SCAN -> IDLE on the cycle after enable sampled 0, regardless of counter position.
REQ-017 SCAN: refresh counter increments each cycle 0..REFRESH_DIV-1, wraps to 0; tick asserted when counter = REFRESH_DIV-1.
REQ-018 On tick, digit pointer advances by 1, wrapping NUM_DIGITS-1 -> 0; frame_done pulses on that wrap tick only.
REQ-019 anode[i] = 0 iff state = SCAN, pointer = i, blank_mask[i] = 0; blank_mask is combinational, not latched.
REQ-020 digit_code = shadow[4*ptr+3 : 4*ptr], registered so it changes on the same edge as anode (no mixed-digit cycle).
REQ-021 Load in IDLE: load_req sampled 1 -> shadow <= data and load_ack pulses on the next edge.
REQ-022 Load in SCAN: capture only on the frame-boundary tick (pointer NUM_DIGITS-1, tick); load_ack pulses in that cycle, so a frame never mixes old and new data.
REQ-023 load_ack SHALL not repeat while load_req stays high; a new capture requires load_req low for at least one cycle.
REQ-024 Simultaneous enable fall and frame-boundary load: load captured, load_ack pulses, then IDLE.
REQ-025 Counter width SHALL be $clog2(REFRESH_DIV); pointer width $clog2(NUM_DIGITS), minimum 1.

Reset
REQ-026 reset SHALL force: state IDLE, counter 0, pointer 0, shadow 0, digit_code 0, anode all 1s, load_ack 0, frame_done 0.
REQ-027 reset mid-frame or mid-load SHALL abort without load_ack; pending load_req re-evaluated from the cycle after reset deasserts.
REQ-028 reset SHALL take priority over enable and load_req in the same cycle.

Structure
REQ-029 Shared package display_pkg SHALL hold the FSM state enumeration and NUM_DIGITS default constant.
REQ-030 Refresh counter and tick SHALL be a sub-module scan_tick_gen (inputs clk, reset, run; output tick).
REQ-031 The segment decoder SHALL remain external; this block drives only digit_code and anode.

Verification (REFRESH_DIV=4, NUM_DIGITS=4)
REQ-032 reset high 2 cycles -> anode=4'b1111, digit_code=0, load_ack=0, frame_done=0.
REQ-033 IDLE, data=16'h4321, load_req=1 -> load_ack one cycle later; enable=1 -> digit_code sequence 1,2,3,4 each for 4 cycles, anode 1110,1101,1011,0111, frame_done after 16 cycles.
REQ-034 SCAN with pointer=1, load_req=1 with data=16'hABCD -> no load_ack until pointer=3 tick; next frame shows D,C,B,A; earlier frame stays 1,2,3,4.
REQ-035 blank_mask=4'b0100 during scan -> anode stays 1111 during digit 2 slot; timing of other digits unchanged.
REQ-036 enable dropped mid-digit-2 -> next cycle anode=1111, pointer 0; re-enable restarts at digit 0 with full 4-cycle slot.
REQ-037 reset asserted while load_req waiting for frame boundary -> no load_ack, shadow=0, IDLE; load_req still high -> load_ack one cycle after reset release.
